// File: rtl/req_enc_pkg.sv
// Shared types and constants for the 8-line request encoder.
package req_enc_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 encoder: index of the highest set bit, plus an any-set flag.
module prio_enc8
  import req_enc_pkg::*;
(
  input  logic [NUM_REQ-1:0] vec,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/req_encoder8.sv
// Synchronises 8 async request lines, queues rising edges as pending bits and presents
// them one at a time on a valid/ready port. Define REQ_ENCODER8_ROUND_ROBIN_EN for round-robin.
//
// state   | meaning
// IDLE    | nothing presented, out_valid=0, out_idx=0
// PRESENT | out_idx holds a pending index, out_valid=1
module req_encoder8
  import req_enc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_idx,
  output logic [NUM_REQ-1:0] pending,
  output logic               overflow
);

  localparam int WARM = SYNC_STAGES + 1;

  logic [NUM_REQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_REQ-1:0] dly_q;
  logic [2:0]         warm_cnt;
  logic [NUM_REQ-1:0] rise;

  state_t             state_q, state_n;
  logic [IDX_W-1:0]   out_idx_q, idx_n;
  logic [NUM_REQ-1:0] pending_q, pending_n;
  logic               overflow_q, overflow_n;

  logic               accept;
  logic [NUM_REQ-1:0] acc_mask;
  logic [NUM_REQ-1:0] cand;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      dly_q    <= '0;
      warm_cnt <= 3'(WARM);
    end else begin
      sync_q[0] <= req_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      dly_q <= sync_q[SYNC_STAGES-1];
      if (warm_cnt != 3'd0) warm_cnt <= warm_cnt - 3'd1;
    end
  end

  // Edges are ignored until the chain has refilled after reset, so a line held high
  // through reset does not look like a fresh request.
  assign rise = (warm_cnt == 3'd0) ? (sync_q[SYNC_STAGES-1] & ~dly_q) : '0;

  assign accept   = (state_q == PRESENT) && out_ready;
  assign acc_mask = accept ? (NUM_REQ'(1) << out_idx_q) : '0;
  assign cand     = pending_q & ~acc_mask;

`ifdef REQ_ENCODER8_ROUND_ROBIN_EN
  logic [IDX_W-1:0]   rr_start_q;
  logic [IDX_W-1:0]   search_start;
  logic [IDX_W:0]     rot_shift;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0] rot_vec;
  logic [IDX_W-1:0]   rot_idx;

  // Rotate so the search start lands on bit 7, then the fixed encoder scans downward.
  always_comb begin
    search_start = (state_q == PRESENT) ? (out_idx_q - 3'd1) : rr_start_q;
    rot_shift    = {1'b0, search_start + 3'd1};
    dbl          = {cand, cand};
    rot_vec      = dbl[rot_shift +: NUM_REQ];
  end

  prio_enc8 u_prio (
    .vec (rot_vec),
    .idx (rot_idx),
    .any (sel_any)
  );

  assign sel_idx = rot_idx + rot_shift[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rr_start_q <= 3'd7;
    else if (accept) rr_start_q <= out_idx_q - 3'd1;
  end
`else
  prio_enc8 u_prio (
    .vec (cand),
    .idx (sel_idx),
    .any (sel_any)
  );
`endif

  always_comb begin
    state_n = state_q;
    idx_n   = out_idx_q;
    case (state_q)
      IDLE: begin
        if (sel_any) begin
          state_n = PRESENT;
          idx_n   = sel_idx;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          if (sel_any) begin
            idx_n = sel_idx;
          end else begin
            state_n = IDLE;
            idx_n   = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase
  end

  // A new edge on the index being accepted re-arms it instead of flagging overflow.
  assign pending_n  = cand | rise;
  assign overflow_n = |(rise & cand);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      out_idx_q  <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      out_idx_q  <= idx_n;
      pending_q  <= pending_n;
      overflow_q <= overflow_n;
    end
  end

  assign out_valid = (state_q == PRESENT);
  assign out_idx   = out_idx_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_req_encoder8.sv
// Self-checking bench for req_encoder8: directed scenarios plus random traffic against a
// cycle-level reference model. Honours REQ_ENCODER8_ROUND_ROBIN_EN like the design.
module tb_req_encoder8;
  import req_enc_pkg::*;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_in;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic [7:0] pending;
  logic       overflow;

  always #5 clk = ~clk;

  req_encoder8 #(.SYNC_STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .pending   (pending),
    .overflow  (overflow)
  );

  int checks = 0;
  int passes = 0;

  logic [7:0] m_pend;
  logic       m_valid;
  logic [2:0] m_idx;
  logic       m_ovf;
  int         m_start;
  logic [7:0] samp[$];

  function automatic int pick(logic [7:0] v, int start);
    for (int k = 0; k < 8; k++) begin
      int j;
      j = (start + 8 - k) % 8;
      if (v[j]) return j;
    end
    return 0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pend  = '0;
    m_valid = 1'b0;
    m_idx   = '0;
    m_ovf   = 1'b0;
    m_start = 7;
    samp.delete();
  endtask

  // One rising edge of the spec-level model: a request is a low-then-high pair of
  // post-reset samples seen S edges later.
  task automatic model_edge();
    logic [7:0] rise, rem;
    bit acc;
    int n, start;
    samp.push_back(req_in);
    if (samp.size() > S + 2) void'(samp.pop_front());
    n = samp.size();
    rise = (n >= S + 2) ? (samp[n-1-S] & ~samp[n-2-S]) : 8'h00;
    acc = m_valid && out_ready;
    rem = m_pend;
    if (acc) rem[m_idx] = 1'b0;
`ifdef REQ_ENCODER8_ROUND_ROBIN_EN
    start = acc ? (int'(m_idx) + 7) % 8 : m_start;
    if (acc) m_start = start;
`else
    start = 7;
`endif
    m_ovf = |(rise & rem);
    if (!m_valid) begin
      if (m_pend != 0) begin
        m_valid = 1'b1;
        m_idx   = 3'(pick(m_pend, start));
      end
    end else if (acc) begin
      if (rem != 0) m_idx = 3'(pick(rem, start));
      else begin
        m_valid = 1'b0;
        m_idx   = '0;
      end
    end
    m_pend = rem | rise;
  endtask

  task automatic compare_all();
    chk("out_valid", out_valid, m_valid);
    chk("out_idx", out_idx, m_idx);
    chk("pending", pending, m_pend);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1 compare_all();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!out_valid && n < budget) begin
      step();
      n++;
    end
    chk("wait_valid", out_valid, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    int got[$];
    int exp_rr[9];
    logic [7:0] cleared;

    exp_rr = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    rst_n = 1'b0;
    req_in = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    repeat (S + 3) step();

    // Single request: valid after S+2 rising edges (visible in the (S+3)th clock period).
    req_in = 8'h04;
    wait_valid(20, n);
    chk("lat_edges", n, S + 2);
    chk("idx_single", out_idx, 2);
    chk("pend_single", pending, 8'h04);
    out_ready = 1'b1;
    req_in = 8'h00;
    step();
    chk("pend_cleared", pending, 8'h00);
    chk("idle_after_accept", out_valid, 0);
    out_ready = 1'b0;

    // Backpressure and overflow on index 5.
    repeat (S + 2) step();
    req_in = 8'h20;
    wait_valid(20, n);
    chk("idx_bp", out_idx, 5);
    req_in = 8'h00;
    repeat (S + 2) step();
    req_in = 8'h20;
    n = 0;
    while (!overflow && n < 20) begin
      step();
      n++;
    end
    chk("ovf_seen", overflow, 1);
    chk("idx_ovf", out_idx, 5);
    chk("pend_ovf", pending, 8'h20);
    step();
    chk("ovf_one_cycle", overflow, 0);
    chk("idx_hold", out_idx, 5);

    // New edge on 5 in the same cycle it is accepted: set wins.
    req_in = 8'h00;
    repeat (S + 2) step();
    req_in = 8'h20;
    repeat (S) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pend_setwins", pending, 8'h20);
    chk("ovf_setwins", overflow, 0);
    step();
    chk("valid_again", out_valid, 1);
    chk("idx_again", out_idx, 5);
    out_ready = 1'b1;
    req_in = 8'h00;
    step();
    out_ready = 1'b0;

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      req_in = req_in ^ 8'($urandom & $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    out_ready = 1'b1;
    req_in = 8'h00;
    repeat (20) step();

    // Reset mid-operation with lines held high.
    out_ready = 1'b0;
    req_in = 8'h0F;
    n = 0;
    while ((pending != 8'h0F || !out_valid) && n < 30) begin
      step();
      n++;
    end
    chk("pend_pre_reset", pending, 8'h0F);
    chk("valid_pre_reset", out_valid, 1);
    do_reset();
    chk("pend_in_reset", pending, 8'h00);
    repeat (12) step();
    chk("pend_held_high", pending, 8'h00);
    chk("valid_held_high", out_valid, 0);
    req_in = 8'h00;
    out_ready = 1'b1;
    repeat (S + 2) step();

`ifdef REQ_ENCODER8_ROUND_ROBIN_EN
    req_in = 8'hFF;
    cleared = 8'h00;
    n = 0;
    while (got.size() < 9 && n < 60) begin
      req_in = req_in | cleared;
      cleared = 8'h00;
      if (out_valid) begin
        got.push_back(int'(out_idx));
        cleared = 8'(1 << out_idx);
        req_in = req_in & ~cleared;
      end
      step();
      n++;
    end
    chk("rr_count", got.size(), 9);
    for (int k = 0; k < 9; k++) chk("rr_seq", (k < got.size()) ? got[k] : -1, exp_rr[k]);
`else
    cleared = 8'h00;
    req_in = 8'h91;
    wait_valid(20, n);
    chk("fixed_first", out_idx, 7);
    step();
    chk("fixed_second", out_idx, 4);
    step();
    chk("fixed_third", out_idx, 0);
    step();
    chk("fixed_done", out_valid, 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/req_encoder8.md
REQ_ENCODER8 -- requirements
Module: req_encoder8

Interface
REQ-001 Parameter SYNC_STAGES, default 2, is the number of synchroniser flops on each req_in bit; legal values are 2..3.
REQ-002 Port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port req_in, input, 8 bits: asynchronous request lines; a rising edge on bit i is one request for index i.
REQ-005 Port out_valid, output, 1 bit: out_idx holds a pending request index.
REQ-006 Port out_ready, input, 1 bit: the downstream consumer accepts out_idx.
REQ-007 Port out_idx, output, 3 bits: the binary index (0..7) of the presented request.
REQ-008 Port pending, output, 8 bits: the registered pending-request vector.
REQ-009 Port overflow, output, 1 bit: a one-cycle pulse when a request arrives for an already-pending index.

Function
REQ-010 Each req_in bit SHALL pass through SYNC_STAGES flops, then a one-flop delay used for rising-edge detection.
REQ-011 A detected rising edge on synchronised bit i SHALL set pending[i] on the next clock.
REQ-012 The FSM SHALL have two states: IDLE (out_valid=0) and PRESENT (out_valid=1).
REQ-013 In IDLE with pending nonzero, the block SHALL load out_idx from the selector and go to PRESENT on the next clock.
REQ-014 In PRESENT, out_idx SHALL stay stable while out_ready=0.
REQ-015 In PRESENT with out_ready=1 (accept), pending[out_idx] SHALL clear.
REQ-016 On the same accept, if other bits remain pending, the block SHALL load the next selected index and stay in PRESENT (back-to-back, no bubble); otherwise it returns to IDLE.
REQ-017 Selection SHALL be made over pending with the just-accepted bit excluded.
REQ-018 If a new edge on bit i coincides with an accept of index i, the set SHALL win: pending[i] stays 1 and overflow stays 0.
REQ-019 An edge on bit i while pending[i]=1 and not being accepted SHALL assert overflow for exactly one cycle; pending is unchanged and the request is merged.
REQ-020 Fixed-priority selection SHALL pick the highest set index (bit 7 highest), matching the 8-to-3 encoding bit i -> binary i.
REQ-021 Latency from the synchronised edge to out_valid SHALL be 2 clocks when IDLE: pending set, then out_valid. End to end from req_in, it is SYNC_STAGES+3 clocks.
REQ-022 out_idx SHALL be 3'd0 whenever out_valid=0.

Reset
REQ-023 rst_n low SHALL asynchronously clear the synchroniser flops, the edge flops, pending, out_valid, out_idx, overflow and the rotation pointer, and force IDLE.
REQ-024 A reset asserted mid-operation SHALL discard all pending requests; after release, a req_in held high SHALL NOT generate a request until it falls and rises again.

Configuration
REQ-025 With macro REQ_ENCODER8_ROUND_ROBIN_EN defined, selection SHALL be round-robin: the search starts at (last accepted index - 1) mod 8 and goes downward with wrap-around; the pointer resets to 7.
REQ-026 Without REQ_ENCODER8_ROUND_ROBIN_EN, selection SHALL be the fixed priority of REQ-020 and the pointer logic SHALL be absent.

Structure
REQ-027 A shared package req_enc_pkg SHALL hold the FSM state typedef (IDLE, PRESENT), the constant NUM_REQ=8 and the constant IDX_W=3.
REQ-028 A sub-module prio_enc8 SHALL implement the combinational 8-bit-to-3-bit highest-set-bit encoder plus an any-set flag.
REQ-029 Round-robin mode SHALL reuse prio_enc8 on a rotated vector and un-rotate the index.

Verification
REQ-030 Reset, then pulse req_in=8'b00000100 -> pending=8'h04, and out_valid=1 with out_idx=3'd2 exactly SYNC_STAGES+3 clocks after the edge; with out_ready=1, pending=8'h00 and IDLE next cycle.
REQ-031 Fixed mode: raise req_in=8'b10010001 at once with out_ready=1 -> out_idx sequence 7,4,0 on consecutive cycles, then out_valid=0.
REQ-032 Round-robin mode: hold pending=8'hFF by re-pulsing every bit after its accept -> out_idx cycles 7,6,5,...,0,7.
REQ-033 Backpressure and overflow: out_ready=0 with idx 5 presented, then re-pulse bit 5 -> overflow high 1 cycle, out_idx stays 5, pending=8'h20; an edge on bit 5 in the accept cycle -> idx 5 is presented again with no overflow.
REQ-034 Reset mid-operation: with pending=8'h0F and out_valid=1, assert rst_n=0 for 1 clock while req_in=8'h0F is held -> all outputs 0 and no request after release until a new edge.
